// File: rtl/oled_char_renderer.sv
// rtl/oled_char_renderer.sv - renders one character code into OLED column bytes via the font ROM
//
// Optional feature macro: OLED_CHAR_INVERT_EN (adds the invert input; all bytes XORed with 0xFF).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   char_valid/ready     character handshake from the text formatter
//   char_code, char_hex  ASCII code, or nibble in [3:0] rendered as a hex digit
//   invert               (OLED_CHAR_INVERT_EN only) highlight cell, sampled on accept
//   font_re, font_addr   font ROM read request
//   font_data            font ROM glyph, registered, valid one cycle after font_re
//   byte_valid/ready     column byte handshake to the OLED data writer
//   byte_data, byte_last column bitmap (bit0 = top pixel), final byte marker
//   busy                 renderer is not idle
module oled_char_renderer #(
  parameter int GAP_COLS    = 1,
  parameter int ADDR_WIDTH  = 8,
  parameter int GLYPH_WIDTH = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   char_valid,
  output logic                   char_ready,
  input  logic [7:0]             char_code,
  input  logic                   char_hex,
`ifdef OLED_CHAR_INVERT_EN
  input  logic                   invert,
`endif
  output logic                   font_re,
  output logic [ADDR_WIDTH-1:0]  font_addr,
  input  logic [GLYPH_WIDTH-1:0] font_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [7:0]             byte_data,
  output logic                   byte_last,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  // Index of the final byte: five glyph columns followed by the gap columns.
  localparam logic [2:0] LAST_COL = 3'(4 + GAP_COLS);

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [GLYPH_WIDTH-1:0] glyph;
  logic [2:0]             col;
  logic [ADDR_WIDTH-1:0]  addr_map;

  // Codes outside the font's printable range fall back to the space glyph.
  always_comb begin
    addr_map = ADDR_WIDTH'(32);
    if (char_hex)
      addr_map = ADDR_WIDTH'(char_code[3:0]);
    else if (char_code >= 8'd32 && char_code <= 8'd122)
      addr_map = ADDR_WIDTH'(char_code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      glyph  <= '0;
      col    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (char_valid) begin
            addr_q <= addr_map;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          glyph <= font_data;
          col   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (byte_ready) begin
            // Shifting zeros in makes the gap columns fall out as 0x00 naturally.
            glyph <= glyph << 8;
            col   <= col + 3'd1;
            if (col == LAST_COL) begin
              col   <= '0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign char_ready = (state == S_IDLE);
  assign font_re    = (state == S_FETCH);
  assign font_addr  = addr_q;
  assign byte_valid = (state == S_SEND);
  assign byte_last  = byte_valid && (col == LAST_COL);
  assign busy       = (state != S_IDLE);

`ifdef OLED_CHAR_INVERT_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inv_q <= 1'b0;
    else if (char_valid && char_ready)
      inv_q <= invert;
  end

  assign byte_data = byte_valid ? (glyph[GLYPH_WIDTH-1 -: 8] ^ {8{inv_q}}) : 8'h00;
`else
  assign byte_data = byte_valid ? glyph[GLYPH_WIDTH-1 -: 8] : 8'h00;
`endif

endmodule

// File: tb/tb_oled_char_renderer.sv
// tb/tb_oled_char_renderer.sv - directed self-checking bench for oled_char_renderer
module tb_oled_char_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [7:0]  char_code = 8'h00;
  logic        char_hex = 1'b0;
`ifdef OLED_CHAR_INVERT_EN
  logic        invert = 1'b0;
`endif
  logic        font_re;
  logic [7:0]  font_addr;
  logic [39:0] font_data = 40'h0;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        busy;

  int total = 0;
  int bad = 0;

  oled_char_renderer #(.GAP_COLS(1), .ADDR_WIDTH(8), .GLYPH_WIDTH(40)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_valid(char_valid), .char_ready(char_ready),
    .char_code(char_code), .char_hex(char_hex),
`ifdef OLED_CHAR_INVERT_EN
    .invert(invert),
`endif
    .font_re(font_re), .font_addr(font_addr), .font_data(font_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_data(byte_data), .byte_last(byte_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] rom(input logic [7:0] a);
    case (a)
      8'd11:   rom = 40'h7F49494936;
      8'd48:   rom = 40'h3E5149453E;
      8'd49:   rom = 40'h00427F4000;
      8'd65:   rom = 40'h7C1211127C;
      8'd69:   rom = 40'h7F49494941;
      8'd90:   rom = 40'h6151494543;
      default: rom = 40'h0;
    endcase
  endfunction

  // Registered font ROM model.
  always @(posedge clk) if (font_re) font_data <= rom(font_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_char_ready"}, char_ready, 1);
    chk({tag, "_font_re"}, font_re, 0);
    chk({tag, "_font_addr"}, font_addr, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_byte_data"}, byte_data, 0);
    chk({tag, "_byte_last"}, byte_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Accept one character, check fetch timing, then the six bytes in order.
  // stall=1 drives byte_ready with the repeating pattern 1,0,0.
  task automatic run_char(input string tag, input logic [7:0] code, input logic hex,
                          input logic [7:0] exp_addr, input logic [47:0] exp_bytes,
                          input bit stall);
    int idx;
    int cyc;
    chk({tag, "_ready_idle"}, char_ready, 1);
    char_code  = code;
    char_hex   = hex;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    chk({tag, "_font_re"}, font_re, 1);
    chk({tag, "_font_addr"}, font_addr, exp_addr);
    chk({tag, "_valid_n1"}, byte_valid, 0);
    tick();
    chk({tag, "_font_re_off"}, font_re, 0);
    chk({tag, "_valid_n2"}, byte_valid, 0);
    chk({tag, "_addr_hold"}, font_addr, exp_addr);
    byte_ready = stall ? 1'b1 : 1'b1;
    tick();
    chk({tag, "_valid_n3"}, byte_valid, 1);
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 60) begin
      byte_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      chk($sformatf("%s_b%0d_valid", tag, idx), byte_valid, 1);
      chk($sformatf("%s_b%0d_data", tag, idx), byte_data, exp_bytes[47 - 8*idx -: 8]);
      chk($sformatf("%s_b%0d_last", tag, idx), byte_last, (idx == 5));
      chk($sformatf("%s_b%0d_rdy", tag, idx), char_ready, 0);
      if (byte_ready) idx++;
      cyc++;
      tick();
    end
    byte_ready = 1'b1;
    chk({tag, "_count"}, idx, 6);
    chk({tag, "_ready_after"}, char_ready, 1);
    chk({tag, "_valid_after"}, byte_valid, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    run_char("A", 8'h41, 1'b0, 8'd65, 48'h7C1211127C00, 1'b0);
    run_char("hexB", 8'h3B, 1'b1, 8'd11, 48'h7F4949493600, 1'b0);
    run_char("del", 8'h7F, 1'b0, 8'd32, 48'h000000000000, 1'b0);
    run_char("lf", 8'h0A, 1'b0, 8'd32, 48'h000000000000, 1'b0);
    run_char("E_stall", 8'h45, 1'b0, 8'd69, 48'h7F4949494100, 1'b1);

    // Abort 'Z' while its third byte is on the bus.
    char_code  = 8'h5A;
    char_hex   = 1'b0;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    chk("Z_font_addr", font_addr, 8'd90);
    tick();
    tick();
    chk("Z_b0", byte_data, 8'h61);
    tick();
    chk("Z_b1", byte_data, 8'h51);
    tick();
    chk("Z_b2", byte_data, 8'h49);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_valid", byte_valid, 0);
    chk("rel_ready", char_ready, 1);
    run_char("zero", 8'h30, 1'b0, 8'd48, 48'h3E5149453E00, 1'b0);

`ifdef OLED_CHAR_INVERT_EN
    invert = 1'b1;
    run_char("inv1", 8'h31, 1'b0, 8'd49, 48'hFFBD80BFFFFF, 1'b0);
    invert = 1'b0;
    run_char("plain1", 8'h31, 1'b0, 8'd49, 48'h00427F400000, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
